key_debouncer: RTL and testbench

- Cleans a raw push-button input (DE-board KEY) and produces single-cycle enable pulses plus a toggled direction level.
- Sits directly upstream of the up/down modulo counter in the Nios II lab designs.
- oPRESS drives the counter's iENABLE; oTOGGLE drives the counter's iUP_DOWN.
- Replaces direct wiring of a bouncing key to the counter, which gives multiple counts per press.

---
 rtl/key_debouncer.sv | 168 ++++++++++++++++
 tb/tb_key_debouncer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
//
// Cleans a raw, bouncing push-button level and turns it into one-cycle
// press/release enable pulses, a debounced level and a direction bit that
// flips on each accepted press. It sits directly upstream of the up/down
// modulo counter: oPRESS feeds the counter enable, oTOGGLE its up/down input.
//
// Parameters:
//   STABLE_CYCLES : consecutive synchronized samples needed to accept a level
//                   change (>= 2). 50000 gives 1 ms at 50 MHz.
//   ACTIVE_LOW    : 1 when the raw key reads 0 while pressed (DE-board KEYs),
//                   0 for active-high sources.
//
// Ports:
//   iCLOCK   : system clock, all state changes on its rising edge
//   iRESET_n : asynchronous active-low reset
//   iKEY     : raw asynchronous key level
//   oLEVEL   : debounced pressed level (1 = pressed), registered
//   oPRESS   : one-cycle pulse on an accepted press, registered
//   oRELEASE : one-cycle pulse on an accepted release, registered
//   oTOGGLE  : flips on every accepted press, registered
// -----------------------------------------------------------------------------
module key_debouncer #(
    parameter int unsigned STABLE_CYCLES = 50000,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic iCLOCK,
    input  logic iRESET_n,
    input  logic iKEY,
    output logic oLEVEL,
    output logic oPRESS,
    output logic oRELEASE,
    output logic oTOGGLE
);

    // Counter width is derived from STABLE_CYCLES and is deliberately not a
    // parameter; the counter only ever has to hold STABLE_CYCLES-1.
    localparam int unsigned      WIDTH    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(STABLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1'b1);

    // Raw key value while the button is not pressed.
    localparam logic IDLE_RAW = ACTIVE_LOW;

    localparam logic [1:0] ST_RELEASED     = 2'd0;
    localparam logic [1:0] ST_WAIT_PRESS   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

    logic             sync1_r;
    logic             sync2_r;
    logic             pressed_s;

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_nxt_s;
    logic             level_r;
    logic             level_nxt_s;
    logic             press_r;
    logic             press_nxt_s;
    logic             release_r;
    logic             release_nxt_s;
    logic             toggle_r;
    logic             toggle_nxt_s;

    // Two-flop synchronizer; resets to the idle raw level so a key held
    // through reset is seen as a fresh press afterwards.
    always_ff @(posedge iCLOCK or negedge iRESET_n) begin
        if (!iRESET_n) begin
            sync1_r <= IDLE_RAW;
            sync2_r <= IDLE_RAW;
        end else begin
            sync1_r <= iKEY;
            sync2_r <= sync1_r;
        end
    end

    // Normalise polarity: 1 means the key is currently pressed.
    assign pressed_s = sync2_r ^ IDLE_RAW;

    // Next-state logic for the debounce FSM, stability counter and outputs.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        level_nxt_s   = level_r;
        toggle_nxt_s  = toggle_r;
        press_nxt_s   = 1'b0;
        release_nxt_s = 1'b0;

        case (state_r)
            ST_RELEASED: begin
                if (pressed_s) begin
                    state_nxt_s = ST_WAIT_PRESS;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_RELEASED;
                end
            end
            ST_WAIT_PRESS: begin
                if (!pressed_s) begin
                    // Bounce: fall back and restart from the stable state.
                    state_nxt_s = ST_RELEASED;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_MAX) begin
                    state_nxt_s  = ST_PRESSED;
                    press_nxt_s  = 1'b1;
                    level_nxt_s  = 1'b1;
                    toggle_nxt_s = ~toggle_r;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!pressed_s) begin
                    state_nxt_s = ST_WAIT_RELEASE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_PRESSED;
                end
            end
            ST_WAIT_RELEASE: begin
                if (pressed_s) begin
                    // Glitch while held: level stays 1, no pulse.
                    state_nxt_s = ST_PRESSED;
                end else if (cnt_r == CNT_MAX) begin
                    state_nxt_s   = ST_RELEASED;
                    release_nxt_s = 1'b1;
                    level_nxt_s   = 1'b0;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_RELEASED;
                cnt_nxt_s   = CNT_ZERO;
                level_nxt_s = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge iCLOCK or negedge iRESET_n) begin
        if (!iRESET_n) begin
            state_r   <= ST_RELEASED;
            cnt_r     <= CNT_ZERO;
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            toggle_r  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            level_r   <= level_nxt_s;
            press_r   <= press_nxt_s;
            release_r <= release_nxt_s;
            toggle_r  <= toggle_nxt_s;
        end
    end

    assign oLEVEL   = level_r;
    assign oPRESS   = press_r;
    assign oRELEASE = release_r;
    assign oTOGGLE  = toggle_r;

endmodule

// File: tb/tb_key_debouncer.sv
// -----------------------------------------------------------------------------
// tb_key_debouncer
//
// Drives an active-low instance and an active-high instance (STABLE_CYCLES=8)
// with mirrored key stimulus; both must show identical output timing.
// Key segments are listed in a table with the hand-computed edge (0-based,
// counted from the first edge that samples the new key value) at which the
// press or release pulse must appear; -1 means no pulse in that segment.
// -----------------------------------------------------------------------------
module tb_key_debouncer;

    logic clk;
    logic rst_n;
    logic key;
    logic key_h;

    logic level_a, press_a, release_a, toggle_a;
    logic level_b, press_b, release_b, toggle_b;

    int checks;
    int errors;

    logic exp_level;
    logic exp_toggle;

    typedef struct {
        string name;
        logic  key;
        int    len;
        int    press_at;
        int    rel_at;
    } seg_t;

    seg_t segs[9];

    key_debouncer #(.STABLE_CYCLES(8), .ACTIVE_LOW(1'b1)) dut_a (
        .iCLOCK   (clk),
        .iRESET_n (rst_n),
        .iKEY     (key),
        .oLEVEL   (level_a),
        .oPRESS   (press_a),
        .oRELEASE (release_a),
        .oTOGGLE  (toggle_a)
    );

    key_debouncer #(.STABLE_CYCLES(8), .ACTIVE_LOW(1'b0)) dut_b (
        .iCLOCK   (clk),
        .iRESET_n (rst_n),
        .iKEY     (key_h),
        .oLEVEL   (level_b),
        .oPRESS   (press_b),
        .oRELEASE (release_b),
        .oTOGGLE  (toggle_b)
    );

    assign key_h = ~key;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic lv, input logic pr,
                             input logic rl, input logic tg);
        check_bit({tag, " level_a"},   level_a,   lv);
        check_bit({tag, " press_a"},   press_a,   pr);
        check_bit({tag, " release_a"}, release_a, rl);
        check_bit({tag, " toggle_a"},  toggle_a,  tg);
        check_bit({tag, " level_b"},   level_b,   lv);
        check_bit({tag, " press_b"},   press_b,   pr);
        check_bit({tag, " release_b"}, release_b, rl);
        check_bit({tag, " toggle_b"},  toggle_b,  tg);
    endtask

    // Apply one key level for len edges, checking outputs 1 time unit after
    // every edge against the expected pulse positions.
    task automatic run_seg(input string name, input logic k, input int len,
                           input int press_at, input int rel_at);
        logic ep;
        logic er;
        key = k;
        for (int i = 0; i < len; i++) begin
            @(posedge clk);
            #1;
            ep = (i == press_at);
            er = (i == rel_at);
            if (ep) begin
                exp_level  = 1'b1;
                exp_toggle = ~exp_toggle;
            end
            if (er) begin
                exp_level = 1'b0;
            end
            check_all($sformatf("%s e%0d", name, i), exp_level, ep, er, exp_toggle);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        exp_level  = 1'b0;
        exp_toggle = 1'b0;

        segs[0] = '{"clean_press",     1'b0, 30, 10, -1};
        segs[1] = '{"clean_release",   1'b1, 20, -1, 10};
        segs[2] = '{"press2",          1'b0, 15, 10, -1};
        segs[3] = '{"glitch_high",     1'b1,  3, -1, -1};
        segs[4] = '{"glitch_recover",  1'b0, 15, -1, -1};
        segs[5] = '{"release2",        1'b1, 15, -1, 10};
        segs[6] = '{"bounce_low",      1'b0,  5, -1, -1};
        segs[7] = '{"bounce_high",     1'b1,  2, -1, -1};
        segs[8] = '{"bounce_settle",   1'b0, 20, 10, -1};

        // Reset held with the key idle: everything reads 0.
        rst_n = 1'b0;
        key   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        run_seg("idle", 1'b1, 5, -1, -1);

        for (int s = 0; s < 9; s++) begin
            run_seg(segs[s].name, segs[s].key, segs[s].len, segs[s].press_at, segs[s].rel_at);
        end

        // Two complete press/release cycles returned the toggle to 0, then
        // the bouncy press set it again.
        check_bit("toggle_after_bounce_a", toggle_a, 1'b1);
        run_seg("release3", 1'b1, 15, -1, 10);

        // Mid-press reset: press, then reset just before edge 6.
        run_seg("pre_reset_press", 1'b0, 6, -1, -1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("mid_press_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_key_low", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n      = 1'b1;
        exp_level  = 1'b0;
        exp_toggle = 1'b0;
        run_seg("post_reset_press", 1'b0, 15, 10, -1);

        // Reset between edges while pressed must clear outputs at once.
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
